// File: rtl/sd_pkg.sv
// Shared types and constants for the sphere-decoder tree-level blocks.
package sd_pkg;

    localparam int NUM_SYM       = 8;
    localparam int SYM_W         = 3;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_PD_WIDTH  = 2 * DEF_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int pd_width(input int width);
        return 2 * width + 4;
    endfunction

endpackage

// File: rtl/rs_enum_scheduler_ped_calc.sv
// Partial Euclidean distance: pd_in + |y - m|^2, saturated to all-ones on overflow.
module ped_calc #(
    parameter int WIDTH    = 32,
    parameter int PD_WIDTH = 2 * WIDTH + 4
) (
    input  logic signed [WIDTH-1:0]    y_real,
    input  logic signed [WIDTH-1:0]    y_imag,
    input  logic signed [WIDTH-1:0]    m_real,
    input  logic signed [WIDTH-1:0]    m_imag,
    input  logic        [PD_WIDTH-1:0] pd_in,
    output logic        [PD_WIDTH-1:0] ped
);

    logic signed [WIDTH:0]     dr;
    logic signed [WIDTH:0]     di;
    logic signed [2*WIDTH+1:0] dr_x;
    logic signed [2*WIDTH+1:0] di_x;
    logic        [2*WIDTH+1:0] sq_r;
    logic        [2*WIDTH+1:0] sq_i;
    logic        [2*WIDTH+2:0] sq_sum;
    logic        [PD_WIDTH:0]  sum;

    assign dr   = $signed({y_real[WIDTH-1], y_real}) - $signed({m_real[WIDTH-1], m_real});
    assign di   = $signed({y_imag[WIDTH-1], y_imag}) - $signed({m_imag[WIDTH-1], m_imag});
    // Widen before squaring so the product is computed at full precision
    assign dr_x = (2*WIDTH+2)'(dr);
    assign di_x = (2*WIDTH+2)'(di);
    assign sq_r = dr_x * dr_x;
    assign sq_i = di_x * di_x;

    assign sq_sum = {1'b0, sq_r} + {1'b0, sq_i};
    assign sum    = (PD_WIDTH+1)'(sq_sum) + {1'b0, pd_in};
    assign ped    = sum[PD_WIDTH] ? {PD_WIDTH{1'b1}} : sum[PD_WIDTH-1:0];

endmodule

// File: rtl/rs_multiplier.sv
// Complex product R*s where s is the 8-point symbol (2*S[1:0]-3) + j*(S[2] ? -1 : +1).
module rs_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] r_real,
    input  logic signed [WIDTH-1:0] r_imag,
    input  logic        [2:0]       s,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag
);

    logic signed [3:0]       sym_re;
    logic signed [3:0]       sym_im;
    logic signed [WIDTH-1:0] sym_re_w;
    logic signed [WIDTH-1:0] sym_im_w;

    // {s[1:0],1} is 2*s+1, so subtracting 4 gives -3, -1, 1, 3
    assign sym_re   = $signed({1'b0, s[1:0], 1'b1}) - 4'sd4;
    assign sym_im   = s[2] ? -4'sd1 : 4'sd1;
    assign sym_re_w = WIDTH'(sym_re);
    assign sym_im_w = WIDTH'(sym_im);

    assign out_real = r_real * sym_re_w - r_imag * sym_im_w;
    assign out_imag = r_real * sym_im_w + r_imag * sym_re_w;

endmodule

// File: rtl/rs_enum_scheduler.sv
// Walks all 8 symbol hypotheses through rs_multiplier and keeps the minimum-ped symbol.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   RUN   | cnt drives S, stage-1 captures {cnt, ped}, compare from 2nd cycle
//   FLUSH | compare the last stage-1 entry, register in_radius
//   DONE  | result presented, waiting for out_ready
module rs_enum_scheduler
    import sd_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PD_WIDTH = 2 * WIDTH + 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    r_real,
    input  logic signed [WIDTH-1:0]    r_imag,
    input  logic signed [WIDTH-1:0]    y_real,
    input  logic signed [WIDTH-1:0]    y_imag,
    input  logic        [PD_WIDTH-1:0] pd_in,
    input  logic        [PD_WIDTH-1:0] radius,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [SYM_W-1:0]    best_sym,
    output logic        [PD_WIDTH-1:0] best_pd,
    output logic                       in_radius
);

    state_t                   state;
    logic        [SYM_W-1:0]  cnt;
    logic signed [WIDTH-1:0]  r_real_q;
    logic signed [WIDTH-1:0]  r_imag_q;
    logic signed [WIDTH-1:0]  y_real_q;
    logic signed [WIDTH-1:0]  y_imag_q;
    logic        [PD_WIDTH-1:0] pd_q;
    logic        [PD_WIDTH-1:0] radius_q;

    logic signed [WIDTH-1:0]  mult_real;
    logic signed [WIDTH-1:0]  mult_imag;
    logic        [PD_WIDTH-1:0] ped_w;

    logic                     s1_valid;
    logic        [SYM_W-1:0]  s1_sym;
    logic        [PD_WIDTH-1:0] s1_ped;

    logic                     upd;
    logic        [PD_WIDTH-1:0] nxt_best_pd;

    rs_multiplier #(.WIDTH(WIDTH)) u_mult (
        .r_real   (r_real_q),
        .r_imag   (r_imag_q),
        .s        (cnt),
        .out_real (mult_real),
        .out_imag (mult_imag)
    );

    ped_calc #(.WIDTH(WIDTH), .PD_WIDTH(PD_WIDTH)) u_ped (
        .y_real (y_real_q),
        .y_imag (y_imag_q),
        .m_real (mult_real),
        .m_imag (mult_imag),
        .pd_in  (pd_q),
        .ped    (ped_w)
    );

    // Strict compare so ties keep the lower (earlier) symbol index
    assign upd         = s1_valid && (s1_ped < best_pd);
    assign nxt_best_pd = upd ? s1_ped : best_pd;

    // Gated with rst_n so in_ready stays low for the whole reset interval
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            r_real_q  <= '0;
            r_imag_q  <= '0;
            y_real_q  <= '0;
            y_imag_q  <= '0;
            pd_q      <= '0;
            radius_q  <= '0;
            s1_valid  <= 1'b0;
            s1_sym    <= '0;
            s1_ped    <= '0;
            out_valid <= 1'b0;
            best_sym  <= '0;
            best_pd   <= '1;
            in_radius <= 1'b0;
        end else begin
            s1_valid <= (state == RUN);
            if (state == RUN) begin
                s1_sym <= cnt;
                s1_ped <= ped_w;
            end
            if (upd) begin
                best_pd  <= s1_ped;
                best_sym <= s1_sym;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_real_q  <= r_real;
                        r_imag_q  <= r_imag;
                        y_real_q  <= y_real;
                        y_imag_q  <= y_imag;
                        pd_q      <= pd_in;
                        radius_q  <= radius;
                        best_pd   <= '1;
                        best_sym  <= '0;
                        in_radius <= 1'b0;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SYM_W'(NUM_SYM - 1)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    out_valid <= 1'b1;
                    in_radius <= (nxt_best_pd <= radius_q);
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
